reduction_accumulator: RTL and testbench
========================================

REDUCTION_ACCUMULATOR -- requirements
Module: reduction_accumulator

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the bit width of each input beat (legal range 1..64).
REQ-002 Parameter MAX_BEATS, default 16, SHALL set the beat-count and popcount saturation limit per frame (legal range 1..1024).
REQ-003 Widths are derived: CNT_W = $clog2(MAX_BEATS+1), POP_W = $clog2(WIDTH*MAX_BEATS+1).
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  input beat valid.
REQ-007 in_ready  output  1  block can accept a beat.
REQ-008 in_data  input  WIDTH  beat data.
REQ-009 in_last  input  1  marks the final beat of a frame.
REQ-010 op  input  3  selects the operation: op[1:0] 00=AND, 01=OR, 10=XOR, 11=XOR (reserved); op[2]=1 inverts the result (NAND/NOR/XNOR).
REQ-011 out_valid  output  1  frame result valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_result  output  1  reduction of all bits of all beats in the frame.
REQ-014 out_count  output  CNT_W  beats accepted in the frame, saturating.
REQ-015 out_popcnt  output  POP_W  number of 1 bits in the frame, saturating.
REQ-016 out_ovf  output  1  frame exceeded MAX_BEATS beats.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCUM and HOLD; a beat is accepted on a rising edge when in_valid and in_ready are both 1.
REQ-018 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-019 In IDLE, an accepted beat SHALL latch op, load the accumulator with the per-beat reduction of in_data, and set count=1 and popcnt=popcount(in_data); the FSM then moves to HOLD if in_last=1, else to ACCUM.
REQ-020 In ACCUM, each accepted beat SHALL fold the per-beat reduction into the accumulator using the latched op, increment count and add popcount(in_data).
REQ-021 Changes on op after the first beat of a frame SHALL be ignored until the next frame.
REQ-022 Inversion (op[2]) SHALL be applied once, to the final frame result only, never per beat.
REQ-023 When an accepted beat has in_last=1, the FSM SHALL enter HOLD and assert out_valid in the next cycle (latency 1 cycle from the last-beat edge).
REQ-024 In HOLD, out_valid, out_result, out_count, out_popcnt and out_ovf SHALL hold stable until out_valid and out_ready are both 1; on that edge the FSM returns to IDLE and out_valid drops.
REQ-025 No beat SHALL be accepted on the cycle of the output handshake, giving a one-cycle bubble between frames.
REQ-026 Beyond MAX_BEATS beats, the block SHALL keep folding data into the result, hold out_count at MAX_BEATS, and set the ovf flag.
REQ-027 popcnt SHALL stop accumulating once the ovf flag is set and SHALL clamp at 2^POP_W-1.
REQ-028 in_valid=0 SHALL leave all state unchanged; the state holds indefinitely in ACCUM with no timeout.
REQ-029 in_last on the first beat SHALL produce a one-beat frame with count=1.

Reset
REQ-030 rst=1 SHALL immediately force IDLE and drive out_valid=0, out_result=0, out_count=0, out_popcnt=0, out_ovf=0 and in_ready=1, and clear the latched op to 000.
REQ-031 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending frame with no output handshake; the first beat after deassertion starts a new frame.

Verification (WIDTH=4, MAX_BEATS=16)
REQ-032 Assert rst mid-ACCUM -> all outputs 0 and in_ready=1 immediately, without waiting for clk; the next frame produces a clean result.
REQ-033 op=000, one beat 4'b1111 with in_last -> next cycle out_valid=1, result=1, count=1, popcnt=4.
REQ-034 op=010, beats 0001, 0011, 0111 (last) -> result=0, count=3, popcnt=6; op changed to 001 during beat 2 has no effect.
REQ-035 op=101 (NOR), beats 0000, 0000 (last) -> result=1, count=2, popcnt=0.
REQ-036 Hold out_ready=0 for 3 cycles after out_valid -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-037 op=001, 17 beats of 0000 then 1000 (last) -> result=1, count=16, popcnt=0, ovf=1.

Source files
------------

// File: rtl/reduction_accumulator.sv
// Frame-based bitwise reduction (AND/OR/XOR, optional invert) with saturating beat count,
// popcount and overflow flag; result held until the downstream handshake.
module reduction_accumulator #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_BEATS = 16,
    localparam int unsigned CNT_W    = $clog2(MAX_BEATS + 1),
    localparam int unsigned POP_W    = $clog2(WIDTH * MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic [CNT_W-1:0] out_count,
    output logic [POP_W-1:0] out_popcnt,
    output logic             out_ovf
);

    typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q;
    logic               acc_q;
    logic [CNT_W-1:0]   count_q;
    logic [POP_W-1:0]   pop_q;
    logic               ovf_q;

    logic               accept;
    logic [1:0]         red_sel;
    logic               beat_red;
    logic [POP_W-1:0]   beat_pop;
    logic [POP_W:0]     pop_sum;
    logic [POP_W-1:0]   pop_sat;
    logic               fold;
    logic               at_max;

    function automatic logic reduce_beat(input logic [WIDTH-1:0] d, input logic [1:0] sel);
        case (sel)
            2'b00:   return &d;
            2'b01:   return |d;
            default: return ^d;
        endcase
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [WIDTH-1:0] d);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt = cnt + POP_W'(d[i]);
        end
        return cnt;
    endfunction

    assign accept   = in_valid && in_ready;
    // First beat of a frame uses the live op; later beats use the latched one.
    assign red_sel  = (state_q == StIdle) ? op[1:0] : op_q[1:0];
    assign beat_red = reduce_beat(in_data, red_sel);
    assign beat_pop = popcount(in_data);
    assign pop_sum  = {1'b0, pop_q} + {1'b0, beat_pop};
    assign pop_sat  = pop_sum[POP_W] ? {POP_W{1'b1}} : pop_sum[POP_W-1:0];
    assign at_max   = (count_q == CNT_W'(MAX_BEATS));

    always_comb begin
        case (op_q[1:0])
            2'b00:   fold = acc_q & beat_red;
            2'b01:   fold = acc_q | beat_red;
            default: fold = acc_q ^ beat_red;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StAccum: begin
                if (accept) begin
                    state_d = in_last ? StHold : StAccum;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready   = (state_q != StHold);
        out_valid  = (state_q == StHold);
        out_result = acc_q ^ op_q[2];
        out_count  = count_q;
        out_popcnt = pop_q;
        out_ovf    = ovf_q;
    end

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= 3'b000;
            acc_q   <= 1'b0;
            count_q <= '0;
            pop_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            if (state_q == StIdle) begin
                op_q    <= op;
                acc_q   <= beat_red;
                count_q <= CNT_W'(1);
                pop_q   <= beat_pop;
                ovf_q   <= 1'b0;
            end else begin
                acc_q <= fold;
                if (at_max) begin
                    ovf_q <= 1'b1;
                end else begin
                    count_q <= count_q + CNT_W'(1);
                    // Popcount only covers beats within the MAX_BEATS window.
                    if (!ovf_q) begin
                        pop_q <= pop_sat;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_reduction_accumulator.sv
// Directed self-checking bench for reduction_accumulator (WIDTH=4, MAX_BEATS=16).
module tb_reduction_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic       out_result;
    logic [4:0] out_count;
    logic [6:0] out_popcnt;
    logic       out_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reduction_accumulator #(
        .WIDTH     (4),
        .MAX_BEATS (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_count  (out_count),
        .out_popcnt (out_popcnt),
        .out_ovf    (out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic r, input int c,
                             input int p, input logic o);
        check({tag, ".valid"},  32'(out_valid),  32'(v));
        check({tag, ".result"}, 32'(out_result), 32'(r));
        check({tag, ".count"},  32'(out_count),  32'(c));
        check({tag, ".popcnt"}, 32'(out_popcnt), 32'(p));
        check({tag, ".ovf"},    32'(out_ovf),    32'(o));
    endtask

    task automatic beat(input logic [3:0] d, input logic last, input logic [2:0] o);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        op       = o;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".hs_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".hs_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        op        = 3'b000;
        out_ready = 1'b0;
        #12;
        check_out("reset", 1'b0, 1'b0, 0, 0, 1'b0);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-beat AND frame
        beat(4'b1111, 1'b1, 3'b000);
        check_out("and1", 1'b1, 1'b1, 1, 4, 1'b0);
        check("and1.in_ready", 32'(in_ready), 32'd0);
        handshake("and1");

        // XOR frame; op change mid-frame must be ignored
        beat(4'b0001, 1'b0, 3'b010);
        beat(4'b0011, 1'b0, 3'b001);
        beat(4'b0111, 1'b1, 3'b001);
        check_out("xor3", 1'b1, 1'b0, 3, 6, 1'b0);

        // Back-pressure: outputs stable, no beats accepted
        in_valid = 1'b1;
        in_data  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_out("hold", 1'b1, 1'b0, 3, 6, 1'b0);
            check("hold.in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        handshake("hold");

        // NOR of zeros
        beat(4'b0000, 1'b0, 3'b101);
        beat(4'b0000, 1'b1, 3'b101);
        check_out("nor2", 1'b1, 1'b1, 2, 0, 1'b0);
        handshake("nor2");

        // Overflow: 17 zero beats then 1000 as last
        for (int i = 0; i < 17; i++) begin
            beat(4'b0000, 1'b0, 3'b001);
        end
        beat(4'b1000, 1'b1, 3'b001);
        check_out("ovf", 1'b1, 1'b1, 16, 0, 1'b1);
        handshake("ovf");

        // Asynchronous reset mid-ACCUM after idling with in_valid low
        beat(4'b1111, 1'b0, 3'b000);
        beat(4'b1111, 1'b0, 3'b000);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("idle_accum.in_ready", 32'(in_ready), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_out("rst_mid", 1'b0, 1'b0, 0, 0, 1'b0);
        check("rst_mid.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        beat(4'b0001, 1'b0, 3'b001);
        beat(4'b0000, 1'b1, 3'b001);
        check_out("post_rst", 1'b1, 1'b1, 2, 1, 1'b0);
        handshake("post_rst");

        // Reset while holding a result discards it
        beat(4'b1111, 1'b1, 3'b000);
        check("pre_rst_hold.valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_out("rst_hold", 1'b0, 1'b0, 0, 0, 1'b0);
        check("rst_hold.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
